// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone stage for the piano play modes.
// Maps a note code and an octave mode to a buzzer square wave.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz, sets every half-period
//   CNT_W   half-period counter width, must hold the low-octave do
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   note     in   4  0 = rest, 1..7 = do..si, 8..15 = rest
//   mode     in   2  00 low, 01 mid, 10 high, 11 mute
//   speaker  out  1  square-wave buzzer drive
//   playing  out  1  high while a tone is generated

module note_tone_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] note,
    input  logic [1:0] mode,
    output logic       speaker,
    output logic       playing
);

    // Mid-octave half-periods in clock cycles, truncated.
    localparam int HP_1 = CLK_HZ / (2 * 262);
    localparam int HP_2 = CLK_HZ / (2 * 294);
    localparam int HP_3 = CLK_HZ / (2 * 330);
    localparam int HP_4 = CLK_HZ / (2 * 349);
    localparam int HP_5 = CLK_HZ / (2 * 392);
    localparam int HP_6 = CLK_HZ / (2 * 440);
    localparam int HP_7 = CLK_HZ / (2 * 494);

    localparam logic [1:0] MODE_LOW  = 2'b00;
    localparam logic [1:0] MODE_MID  = 2'b01;
    localparam logic [1:0] MODE_HIGH = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    // The low-octave do is the longest half-period in use.
    if ((longint'(HP_1) << 1) >= (longint'(1) << CNT_W)) begin : g_cnt_chk
        $error("note_tone_gen: CNT_W too small for low-octave do");
    end

    logic [3:0]       r_note_q;
    logic [1:0]       r_mode_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_speaker;
    logic             r_playing;

    logic [3:0]       w_note_d;
    logic [1:0]       w_mode_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_speaker_d;
    logic             w_playing_d;

    logic [CNT_W-1:0] w_hp_base;
    logic [CNT_W-1:0] w_hp;
    logic             w_change;
    logic             w_new_valid;
    logic             w_hp_done;

    // Base half-period of the captured note.
    always_comb begin
        w_hp_base = '0;
        case (r_note_q)
            4'd1:    w_hp_base = CNT_W'(HP_1);
            4'd2:    w_hp_base = CNT_W'(HP_2);
            4'd3:    w_hp_base = CNT_W'(HP_3);
            4'd4:    w_hp_base = CNT_W'(HP_4);
            4'd5:    w_hp_base = CNT_W'(HP_5);
            4'd6:    w_hp_base = CNT_W'(HP_6);
            4'd7:    w_hp_base = CNT_W'(HP_7);
            default: w_hp_base = '0;
        endcase
    end

    // Octave scaling; mute never reaches the counter.
    always_comb begin
        w_hp = '0;
        case (r_mode_q)
            MODE_LOW:  w_hp = w_hp_base << 1;
            MODE_MID:  w_hp = w_hp_base;
            MODE_HIGH: w_hp = w_hp_base >> 1;
            default:   w_hp = '0;
        endcase
    end

    assign w_change    = {note, mode} != {r_note_q, r_mode_q};
    assign w_new_valid = (note != 4'd0) && (note <= 4'd7)
                      && (mode != MODE_MUTE);
    assign w_hp_done   = (r_cnt == w_hp - CNT_W'(1));

    // Next-state logic. A change always restarts from phase 0,
    // which also covers a shorter half-period arriving mid-count.
    always_comb begin
        w_note_d    = r_note_q;
        w_mode_d    = r_mode_q;
        w_cnt_d     = r_cnt;
        w_speaker_d = r_speaker;
        w_playing_d = r_playing;
        if (w_change) begin
            w_note_d    = note;
            w_mode_d    = mode;
            w_cnt_d     = '0;
            w_speaker_d = 1'b0;
            w_playing_d = w_new_valid;
        end else if (r_playing) begin
            if (w_hp_done) begin
                w_cnt_d     = '0;
                w_speaker_d = ~r_speaker;
            end else begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_d     = '0;
            w_speaker_d = 1'b0;
        end
    end

    // mode_q resets to mute so a held key restarts after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_note_q  <= 4'd0;
            r_mode_q  <= MODE_MUTE;
            r_cnt     <= '0;
            r_speaker <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_note_q  <= w_note_d;
            r_mode_q  <= w_mode_d;
            r_cnt     <= w_cnt_d;
            r_speaker <= w_speaker_d;
            r_playing <= w_playing_d;
        end
    end

    assign speaker = r_speaker;
    assign playing = r_playing;

endmodule
